// File: rtl/uart_tx_mmio_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : register map, status bit positions and FSM encoding   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVERRUN = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // FIFO occupancy as reported in the 4-bit STATUS count field.
  function automatic logic [3:0] sat_count(input int unsigned v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_mmio_if : CPU-side register bus of the UART transmitter  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface uart_tx_mmio_if;
  logic        cs;
  logic        rw;
  logic [1:0]  reg_sel;
  logic [15:0] data_in;
  logic [15:0] data_out;

  modport master (output cs, output rw, output reg_sel, output data_in, input data_out);
  modport slave  (input cs, input rw, input reg_sel, input data_in, output data_out);
endinterface
`default_nettype wire

// File: rtl/uart_tx_mmio_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo : first-word-fall-through FIFO, push+pop legal when full|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_mmio : memory-mapped 8N1 UART transmitter with FIFO      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           txd
);
  tx_state_t   state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] frame_div_q, frame_div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        ovr_q, ovr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] status;

  logic        wr_en, rd_en, bit_end, pop, push_req, push;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign wr_en    = bus.cs && !bus.rw;
  assign rd_en    = bus.cs && bus.rw;
  assign bit_end  = (cnt_q == frame_div_q);
  assign pop      = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign push_req = wr_en && (bus.reg_sel == REG_DATA);
  assign push     = push_req && (!fifo_full || pop);

  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (bus.data_in[7:0]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_end) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Bit timing and the next txd level are decided here so txd is a pure flop.
  always_comb begin
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_div_d = frame_div_q;
    txd_d       = 1'b1;
    if (pop) begin
      cnt_d       = '0;
      bit_d       = '0;
      shift_d     = fifo_dout;
      frame_div_d = div_q;
    end else if (state_q != IDLE) begin
      if (bit_end) begin
        cnt_d = '0;
        if (state_q == DATA) begin
          bit_d   = bit_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (wr_en && (bus.reg_sel == REG_DIV)) div_d = bus.data_in;
    // A drop in the same cycle as a STATUS read wins over the clear.
    ovr_d = ovr_q;
    if (rd_en && (bus.reg_sel == REG_STATUS)) ovr_d = 1'b0;
    if (push_req && !push) ovr_d = 1'b1;
    status                        = '0;
    status[STAT_BUSY]             = (state_q != IDLE);
    status[STAT_FULL]             = fifo_full;
    status[STAT_EMPTY]            = fifo_empty;
    status[STAT_OVERRUN]          = ovr_q;
    status[STAT_CNT_LSB +: 4]     = sat_count(32'(fifo_count));
    rdata_d = '0;
    if (rd_en) begin
      case (bus.reg_sel)
        REG_STATUS: rdata_d = status;
        REG_DIV:    rdata_d = div_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= DIV_RESET;
      frame_div_q <= DIV_RESET;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
      ovr_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      div_q       <= div_d;
      frame_div_q <= frame_div_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
      ovr_q       <= ovr_d;
      rdata_q     <= rdata_d;
    end
  end

  assign txd          = txd_q;
  assign bus.data_out = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx_mmio : directed bench with a frame-decoding txd model |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart_tx_mmio;
  logic clk;
  logic reset;
  logic txd;

  uart_tx_mmio_if bus_if();

  uart_tx_mmio #(.FIFO_DEPTH(8), .DIV_RESET(16'd867)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .txd   (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int frame_cnt   = 0;
  int last_end    = 0;
  int m_div       = 867;
  logic [7:0] exp_q [$];
  int         starts [$];

  // Model state: one frame in flight, expected bits from the byte and bit period.
  bit         active = 1'b0;
  bit         stray  = 1'b0;
  bit         bad    = 1'b0;
  logic       bad_val;
  logic       e;
  logic [7:0] cur;
  int         per, k, bidx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      active = 1'b0;
      stray  = 1'b0;
      exp_q.delete();
    end else if (!active) begin
      if (txd == 1'b0) begin
        if (exp_q.size() == 0) begin
          if (!stray) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: txd went low at cycle %0d, want no frame", cyc);
            stray = 1'b1;
          end
        end else begin
          active = 1'b1;
          cur    = exp_q.pop_front();
          per    = m_div + 1;
          k      = 0;
          bad    = 1'b0;
          starts.push_back(cyc);
        end
      end else begin
        stray = 1'b0;
      end
    end
    if (active) begin
      bidx = k / per;
      if (bidx == 0)      e = 1'b0;
      else if (bidx == 9) e = 1'b1;
      else                e = cur[bidx-1];
      if ((txd !== e) && !bad) begin
        bad     = 1'b1;
        bad_val = txd;
      end
      if ((k % per) == per - 1) begin
        vectors++;
        if (bad) begin
          miscompares++;
          $display("FAIL frame_bit%0d byte 0x%02h: txd %0b, want %0b", bidx, cur, bad_val, e);
        end
        bad = 1'b0;
      end
      k++;
      if (k == 10 * per) begin
        active = 1'b0;
        frame_cnt++;
        last_end = cyc;
      end
    end
  end

  task automatic bus_write(input logic [1:0] sel, input logic [15:0] data, input bit expect_tx);
    @(posedge clk); #1;
    bus_if.cs = 1'b1; bus_if.rw = 1'b0; bus_if.reg_sel = sel; bus_if.data_in = data;
    @(posedge clk); #1;
    bus_if.cs = 1'b0;
    if (sel == 2'd2) m_div = int'(data);
    if (sel == 2'd0 && expect_tx) exp_q.push_back(data[7:0]);
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [15:0] val);
    @(posedge clk); #1;
    bus_if.cs = 1'b1; bus_if.rw = 1'b1; bus_if.reg_sel = sel;
    @(posedge clk); #1;
    bus_if.cs = 1'b0; bus_if.rw = 1'b0;
    @(negedge clk);
    val = bus_if.data_out;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frame_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, frame_cnt, target);
  endtask

  initial begin
    logic [15:0] v;
    int f0, n0;
    bus_if.cs = 1'b0; bus_if.rw = 1'b0; bus_if.reg_sel = 2'd0; bus_if.data_in = 16'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_dout", bus_if.data_out, 0);
    bus_read(2'd1, v); chk("reset_status", v, 16'h0004);
    bus_read(2'd2, v); chk("reset_div", v, 16'd867);

    // Single 0x55 frame at 4-clock bits, sampled by hand.
    bus_write(2'd2, 16'd3, 1'b0);
    bus_write(2'd0, 16'h0055, 1'b1);
    @(negedge clk); chk("t1_before_pop", txd, 1);
    @(negedge clk); chk("t1_start_bit", txd, 0);
    for (int i = 1; i < 10; i++) begin
      repeat (4) @(negedge clk);
      chk("t1_bit", txd, i % 2);
    end
    repeat (4) @(negedge clk); chk("t1_after_frame", txd, 1);
    wait_frames(1, 50, "t1_frames");
    chk("t1_length", last_end - starts[0] + 1, 40);
    bus_read(2'd1, v); chk("t1_status_idle", v, 16'h0004);

    // Three back-to-back bytes.
    f0 = frame_cnt; n0 = starts.size();
    bus_write(2'd0, 16'h0001, 1'b1);
    bus_write(2'd0, 16'h0080, 1'b1);
    bus_write(2'd0, 16'h00FF, 1'b1);
    wait_frames(f0 + 3, 300, "t2_frames");
    if (starts.size() >= n0 + 3) begin
      chk("t2_gap01", starts[n0+1] - starts[n0], 40);
      chk("t2_gap12", starts[n0+2] - starts[n0+1], 40);
      chk("t2_span", last_end - starts[n0] + 1, 120);
    end

    // Overrun with a slow first frame, then speed up the rest.
    bus_write(2'd2, 16'd1000, 1'b0);
    f0 = frame_cnt;
    for (int i = 0; i < 10; i++) bus_write(2'd0, 16'(16'h30 + i), (i < 9));
    bus_read(2'd1, v); chk("t3_status_overrun", v, 16'h008B);
    bus_read(2'd1, v); chk("t3_status_cleared", v, 16'h0083);
    bus_write(2'd2, 16'd3, 1'b0);
    wait_frames(f0 + 9, 12000, "t3_frames");
    repeat (60) @(negedge clk);
    chk("t3_only_nine", frame_cnt, f0 + 9);
    chk("t3_queue_drained", exp_q.size(), 0);
    bus_read(2'd1, v); chk("t3_status_idle", v, 16'h0004);

    // Divisor rewritten mid-frame applies to the next frame only.
    f0 = frame_cnt; n0 = starts.size();
    bus_write(2'd0, 16'h00A5, 1'b1);
    repeat (5) @(posedge clk);
    bus_write(2'd2, 16'd7, 1'b0);
    bus_write(2'd0, 16'h003C, 1'b1);
    wait_frames(f0 + 2, 300, "t4_frames");
    if (starts.size() >= n0 + 2) begin
      chk("t4_first_len", starts[n0+1] - starts[n0], 40);
      chk("t4_second_len", last_end - starts[n0+1] + 1, 80);
    end

    // Reset during data bit 4 of 0x0F (a low bit).
    bus_write(2'd2, 16'd3, 1'b0);
    bus_write(2'd0, 16'h000F, 1'b1);
    repeat (22) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); chk("t5_txd_before_reset", txd, 0);
    @(posedge clk);
    @(negedge clk); chk("t5_txd_after_reset", txd, 1);
    @(posedge clk); #1 reset = 1'b0;
    m_div = 867;
    bus_read(2'd1, v); chk("t5_status", v, 16'h0004);
    bus_read(2'd2, v); chk("t5_div", v, 16'd867);

    // Read-port behaviour.
    bus_write(2'd2, 16'hBEEF, 1'b0);
    bus_write(2'd3, 16'h1234, 1'b0);
    bus_read(2'd2, v); chk("t6_div_read", v, 16'hBEEF);
    @(negedge clk); chk("t6_dout_back_to_zero", bus_if.data_out, 0);
    bus_read(2'd3, v); chk("t6_reserved_read", v, 0);
    bus_read(2'd0, v); chk("t6_data_read", v, 0);
    chk("t6_no_frames", frame_cnt, f0 + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU bus, beside the RAM and the LED display register. It takes 16-bit CPU writes decoded by the top-level address logic, buffers bytes in a small FIFO, and serialises them as 8N1 frames on `txd`. Status and the baud divisor are readable through a registered read port with the same one-cycle latency as the RAM, so `top` can OR the read data into the CPU data-in path.

## Interface
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of two, at least 2.
- `DIV_RESET`, 16'd867: divisor reset value. Bit period is divisor+1 clocks.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `cs` in 1: block select from the top-level address decode.
- `rw` in 1: 1 = read, 0 = write, using CPU convention.
- `reg_sel` in 2: register offset (CPU `addr[1:0]`).
- `data_in` in 16: CPU write data.
- `data_out` out 16: registered read data; 0 when not returning a read.
- `txd` out 1: serial output, idle high.

## Operation
- Register map (`reg_sel`):
  - 0 DATA: write pushes `data_in[7:0]` into the FIFO; read returns 0.
  - 1 STATUS (read-only): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overrun (sticky), bits[7:4] FIFO count (saturating to 15), all other bits 0.
  - 2 DIVISOR: read/write, 16 bits.
  - 3: reserved; writes are ignored, reads return 0.
- Write to DATA when the FIFO is full: the byte is dropped and overrun is set. If the FSM pops in the same cycle, the write is accepted and overrun is not set.
- Reading STATUS clears overrun on the same edge. If an overrun occurs in that same cycle, overrun stays 1, and the returned value is the pre-clear value.
- FSM states:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `txd`=0 for divisor+1 clocks, then go to DATA.
  - DATA: shift out 8 bits LSB first, each for divisor+1 clocks, then go to STOP.
  - STOP: `txd`=1 for divisor+1 clocks. At the end, if the FIFO is non-empty, pop and go directly to START (no idle cycle); otherwise go to IDLE.
- The divisor is latched into the bit-period counter when each frame starts. Writing DIVISOR mid-frame affects only later frames. Divisor 0 gives a 1-clock bit period.
- `reset` mid-frame returns the FSM to IDLE, empties the FIFO, and drives `txd` to 1 on the next edge. A truncated frame is acceptable.

## Timing
- Reset values: `txd`=1, `data_out`=0, FSM=IDLE, FIFO empty, overrun=0, divisor=`DIV_RESET`.
- A write is sampled on the rising edge while `cs`=1 and `rw`=0. Its effect on the FIFO or DIVISOR is visible after that edge.
- TX latency: DATA write accepted at edge E with the FSM idle → pop at E+1 → `txd`=0 from E+1.
- A frame lasts exactly 10×(divisor+1) clocks. Back-to-back frames have no gap.
- Reads: `cs`=1 and `rw`=1 at edge E puts register data on `data_out` after E, held for one cycle. After the following edge, `data_out` returns to 0 unless another read is in progress.
- `txd` comes straight from a flop, never from combinational logic.

## Structure
- `uart_pkg`: `REG_DATA`, `REG_STATUS`, `REG_DIV` constants; STATUS bit-index constants; `tx_state_t` enum {IDLE, START, DATA, STOP}.
- Sub-module `sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH))`: push, pop, full, empty, count. Simultaneous push and pop is legal at any fill level, including full.
- The top-level decode drives `cs`; its read data is ORed into `cpu_data_in` with the RAM output.

## Test plan
- Reset, then write DIVISOR=3 and DATA=0x55 → `txd` low from the next cycle. Bits sample as 0,1,0,1,0,1,0,1,0,1 at 4-clock spacing; frame is 40 clocks; then `txd`=1 and busy=0.
- Divisor 3, write 3 bytes back-to-back (0x01, 0x80, 0xFF) → 120 contiguous clocks with no idle gap; decoded bytes match in order.
- Divisor 1000, write 10 bytes → the first pops immediately and 8 fill the FIFO (full=1, count=8). The 10th write sets overrun; reading STATUS returns bit3=1, the next read returns bit3=0. Only 9 bytes are transmitted.
- Write DIVISOR=7 during a divisor-3 frame → the current frame keeps 4-clock bits; the next frame uses 8-clock bits.
- Assert `reset` during DATA bit 4 → the next edge gives `txd`=1, STATUS reads empty=1, busy=0, and DIVISOR reads back as 867.
- Read DIVISOR after writing 0xBEEF → `data_out`=0xBEEF for exactly one cycle, then 0; a read of register 3 returns 0.
